// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word lines.
// Hits are zero-latency; a miss fills one word from memory and then hits.
module icache_direct #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        flush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int IW = $clog2(SETS);
   localparam int TW = 30 - IW;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t            state_q;
   logic [31:0]       addr_q;
   logic              iren_q;
   logic [SETS-1:0]   valid_q;
   logic [TW-1:0]     tag_q  [SETS];
   logic [31:0]       data_q [SETS];
   logic [31:0]       hit_cnt_q, hit_cnt_d;
   logic [31:0]       miss_cnt_q, miss_cnt_d;

   logic [IW-1:0]     req_idx, fill_idx;
   logic [TW-1:0]     req_tag, fill_tag;
   logic              hit_raw, miss_go, fill_go;
   logic              unused_offset;

   assign req_idx       = imemaddr[IW+1:2];
   assign req_tag       = imemaddr[31:IW+2];
   assign fill_idx      = addr_q[IW+1:2];
   assign fill_tag      = addr_q[31:IW+2];
   assign unused_offset = ^imemaddr[1:0];

   always_comb begin
      hit_raw    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
      // A flush cycle never reports a hit, so the datapath cannot consume a line being invalidated.
      ihit       = (state_q == IDLE) && imemREN && !flush && hit_raw;
      imemload   = ihit ? data_q[req_idx] : 32'h0;
      miss_go    = (state_q == IDLE) && imemREN && !ihit;
      fill_go    = (state_q == FETCH) && !iwait;
      hit_cnt_d  = (ihit && (hit_cnt_q != 32'hFFFF_FFFF)) ? hit_cnt_q + 32'd1 : hit_cnt_q;
      miss_cnt_d = (miss_go && (miss_cnt_q != 32'hFFFF_FFFF)) ? miss_cnt_q + 32'd1 : miss_cnt_q;
   end

   assign iREN       = iren_q;
   assign iaddr      = iren_q ? addr_q : 32'h0;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         iren_q     <= 1'b0;
         addr_q     <= 32'h0;
         valid_q    <= '0;
         hit_cnt_q  <= 32'h0;
         miss_cnt_q <= 32'h0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         case (state_q)
            IDLE: begin
               if (miss_go) begin
                  addr_q  <= {imemaddr[31:2], 2'b00};
                  iren_q  <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               if (!iwait) begin
                  iren_q  <= 1'b0;
                  state_q <= IDLE;
                  if (!flush) valid_q[fill_idx] <= 1'b1;
               end
            end
            default: begin
               iren_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
         if (flush) valid_q <= '0;
      end
   end

   // Tag/data storage carries no reset; the valid bits alone qualify it.
   always_ff @(posedge CLK) begin
      if (!RST && fill_go) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= iload;
      end
   end

endmodule
